// File: rtl/fir_pkg.sv
// Shared widths and output scaling for the symmetric I/Q FIR.
// Imported by the rail datapath and the top level.
package fir_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int acc_width(input int dw, input int cw, input int n);
    return dw + cw + 1 + clog2(n / 2);
  endfunction

  // Round half up, drop shift LSBs, clamp to a dw-bit signed range.
  function automatic logic signed [127:0] round_sat(
    input logic signed [127:0] acc,
    input int                  shift,
    input int                  dw
  );
    logic signed [127:0] r, mx, mn;
    r  = (acc + (128'sd1 <<< (shift - 1))) >>> shift;
    mx = (128'sd1 <<< (dw - 1)) - 128'sd1;
    mn = -mx - 128'sd1;
    if (r > mx) r = mx;
    else if (r < mn) r = mn;
    return r;
  endfunction

endpackage

// File: rtl/fir_sym_rail.sv
// One real rail of the symmetric FIR: delay line, pre-add,
// multiply, pipelined adder tree and round/saturate.
module fir_sym_rail
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int COEFF_WIDTH = 16,
  parameter int NUM_COEFFS  = 4096
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    en,
  input  logic                                    shift,
  input  logic [DATA_WIDTH-1:0]                   din,
  input  logic [(NUM_COEFFS/2)*COEFF_WIDTH-1:0]   coeffs,
  output logic [DATA_WIDTH-1:0]                   dout
);

  localparam int N  = NUM_COEFFS;
  localparam int H  = N / 2;
  localparam int L  = clog2(H);
  localparam int P  = 1 << L;
  localparam int PW = DATA_WIDTH + 1;
  localparam int MW = DATA_WIDTH + COEFF_WIDTH + 1;
  localparam int AW = acc_width(DATA_WIDTH, COEFF_WIDTH, N);

  logic signed [DATA_WIDTH-1:0]  dl [N];
  logic signed [PW-1:0]          pa [H];
  logic signed [MW-1:0]          mu [H];
  logic signed [COEFF_WIDTH-1:0] h  [H];

  for (genvar k = 0; k < H; k++) begin : g_h
    assign h[k] = coeffs[k*COEFF_WIDTH +: COEFF_WIDTH];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) dl[i] <= '0;
    end else if (shift) begin
      dl[0] <= din;
      for (int i = 1; i < N; i++) dl[i] <= dl[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < H; k++) begin
        pa[k] <= '0;
        mu[k] <= '0;
      end
    end else if (en) begin
      for (int k = 0; k < H; k++) begin
        pa[k] <= PW'(dl[k]) + PW'(dl[N-1-k]);
        mu[k] <= MW'(pa[k]) * MW'(h[k]);
      end
    end
  end

  // Level 0 is the product row padded with zeros to a power of two.
  for (genvar l = 0; l <= L; l++) begin : g_lv
    logic signed [AW-1:0] s [P >> l];
    if (l == 0) begin : g_leaf
      for (genvar k = 0; k < P; k++) begin : g_k
        if (k < H) begin : g_m
          assign s[k] = AW'(mu[k]);
        end else begin : g_z
          assign s[k] = '0;
        end
      end
    end else begin : g_add
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int j = 0; j < (P >> l); j++) s[j] <= '0;
        end else if (en) begin
          for (int j = 0; j < (P >> l); j++)
            s[j] <= g_lv[l-1].s[2*j] + g_lv[l-1].s[2*j+1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) dout <= '0;
    else if (en)
      dout <= DATA_WIDTH'(round_sat(128'(g_lv[L].s[0]),
                                    COEFF_WIDTH - 1, DATA_WIDTH));
  end

endmodule

// File: rtl/fir_filter_iq.sv
// Streaming I/Q symmetric FIR: serial coefficient bank,
// valid/last side pipeline and two real filter rails.
module fir_filter_iq
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int COEFF_WIDTH = 16,
  parameter int NUM_COEFFS  = 4096
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_tvalid,
  input  logic                   in_tlast,
  output logic                   in_tready,
  input  logic [DATA_WIDTH-1:0]  in_i,
  input  logic [DATA_WIDTH-1:0]  in_q,
  input  logic [COEFF_WIDTH-1:0] coeff_in,
  input  logic                   reload_coeff,
  input  logic                   out_tready,
  output logic                   out_tvalid,
  output logic                   out_tlast,
  output logic [DATA_WIDTH-1:0]  out_i,
  output logic [DATA_WIDTH-1:0]  out_q
);

  localparam int H   = NUM_COEFFS / 2;
  localparam int LAT = 4 + clog2(H);
  localparam int BW  = H * COEFF_WIDTH;

  logic           en;
  logic           accept;
  logic [BW-1:0]  bank;
  logic [LAT-1:0] vpipe;
  logic [LAT-1:0] lpipe;

  assign en        = out_tready;
  assign in_tready = out_tready;
  assign accept    = in_tvalid & out_tready;

  // New words enter at the top; the first word ends up as h[0].
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) bank <= '0;
    else if (!reload_coeff)
      bank <= {coeff_in, bank[BW-1:COEFF_WIDTH]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vpipe <= '0;
      lpipe <= '0;
    end else if (en) begin
      vpipe <= {vpipe[LAT-2:0], in_tvalid};
      lpipe <= {lpipe[LAT-2:0], in_tvalid & in_tlast};
    end
  end

  assign out_tvalid = vpipe[LAT-1];
  assign out_tlast  = lpipe[LAT-1];

  fir_sym_rail #(
    .DATA_WIDTH (DATA_WIDTH),
    .COEFF_WIDTH(COEFF_WIDTH),
    .NUM_COEFFS (NUM_COEFFS)
  ) u_rail_i (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .shift (accept),
    .din   (in_i),
    .coeffs(bank),
    .dout  (out_i)
  );

  fir_sym_rail #(
    .DATA_WIDTH (DATA_WIDTH),
    .COEFF_WIDTH(COEFF_WIDTH),
    .NUM_COEFFS (NUM_COEFFS)
  ) u_rail_q (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .shift (accept),
    .din   (in_q),
    .coeffs(bank),
    .dout  (out_q)
  );

endmodule

// File: tb/tb_fir_filter_iq.sv
// Bench for fir_filter_iq with 8 taps: directed impulse, saturation,
// handshake and reset cases plus random traffic against a direct-form model.
module tb_fir_filter_iq;

  localparam int N   = 8;
  localparam int H   = 4;
  localparam int LAT = 6;

  logic        clk = 0;
  logic        reset;
  logic        in_tvalid, in_tlast, in_tready;
  logic [15:0] in_i, in_q, coeff_in;
  logic        reload_coeff, out_tready;
  logic        out_tvalid, out_tlast;
  logic [15:0] out_i, out_q;

  always #5 clk = ~clk;

  fir_filter_iq #(
    .DATA_WIDTH (16),
    .COEFF_WIDTH(16),
    .NUM_COEFFS (N)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_tvalid   (in_tvalid),
    .in_tlast    (in_tlast),
    .in_tready   (in_tready),
    .in_i        (in_i),
    .in_q        (in_q),
    .coeff_in    (coeff_in),
    .reload_coeff(reload_coeff),
    .out_tready  (out_tready),
    .out_tvalid  (out_tvalid),
    .out_tlast   (out_tlast),
    .out_i       (out_i),
    .out_q       (out_q)
  );

  int checks = 0;
  int failures = 0;

  int hm[H];
  int xi[N];
  int xq[N];
  int eq_i[$];
  int eq_q[$];
  bit eq_l[$];
  int oi[$];
  int oq[$];
  bit ol[$];

  task automatic chk(string tag, int got, int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int ref_y(int x[N]);
    longint acc;
    acc = 0;
    for (int k = 0; k < H; k++)
      acc += longint'(hm[k]) * longint'(x[k] + x[N-1-k]);
    acc = (acc + 16384) >>> 15;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    return int'(acc);
  endfunction

  task automatic cycle();
    bit fire, lst;
    int gi, gq;
    fire = out_tvalid && out_tready;
    gi   = $signed(out_i);
    gq   = $signed(out_q);
    lst  = out_tlast;
    if (in_tvalid && out_tready) begin
      for (int k = N - 1; k > 0; k--) begin
        xi[k] = xi[k-1];
        xq[k] = xq[k-1];
      end
      xi[0] = $signed(in_i);
      xq[0] = $signed(in_q);
      eq_i.push_back(ref_y(xi));
      eq_q.push_back(ref_y(xq));
      eq_l.push_back(in_tlast);
    end
    if (!reload_coeff) begin
      for (int k = 0; k < H - 1; k++) hm[k] = hm[k+1];
      hm[H-1] = $signed(coeff_in);
    end
    @(posedge clk);
    #1;
    if (fire) begin
      if (eq_i.size() == 0) begin
        chk("spurious_out", 1, 0);
      end else begin
        chk("out_i", gi, eq_i.pop_front());
        chk("out_q", gq, eq_q.pop_front());
        chk("out_last", int'(lst), int'(eq_l.pop_front()));
      end
      oi.push_back(gi);
      oq.push_back(gq);
      ol.push_back(lst);
    end
  endtask

  task automatic drive(bit v, int i, int q, bit l);
    in_tvalid = v;
    in_i      = 16'(i);
    in_q      = 16'(q);
    in_tlast  = l;
  endtask

  task automatic drain();
    drive(0, 0, 0, 0);
    out_tready = 1;
    repeat (LAT + 4) cycle();
    chk("drained", eq_i.size(), 0);
  endtask

  task automatic load(int c[H]);
    drain();
    reload_coeff = 0;
    for (int k = 0; k < H; k++) begin
      coeff_in = 16'(c[k]);
      cycle();
    end
    reload_coeff = 1;
  endtask

  task automatic clear_obs();
    oi.delete();
    oq.delete();
    ol.delete();
  endtask

  task automatic impulse(string tag, int ai, int aq, int stall_at,
                         int ti[8], int tq[8]);
    int lat, steps;
    lat   = -1;
    steps = 0;
    clear_obs();
    for (int s = 0; s < 16; s++) begin
      drive(1, (s == 0) ? ai : 0, (s == 0) ? aq : 0, 0);
      if (s == stall_at) begin
        repeat (3) begin
          out_tready = 0;
          chk({tag, "_in_tready_stall"}, int'(in_tready), 0);
          cycle();
          steps++;
          if (lat < 0 && out_tvalid) lat = steps;
        end
        out_tready = 1;
      end
      cycle();
      steps++;
      if (lat < 0 && out_tvalid) lat = steps;
    end
    drain();
    chk({tag, "_latency"}, lat, (stall_at >= 0) ? LAT + 3 : LAT);
    chk({tag, "_count"}, oi.size(), 16);
    if (oi.size() >= 8) begin
      for (int k = 0; k < 8; k++) begin
        chk({tag, "_seq_i"}, oi[k], ti[k]);
        chk({tag, "_seq_q"}, oq[k], tq[k]);
      end
    end
  endtask

  int c1[H]   = '{32'h1000, 32'h2000, 32'h3000, 32'h4000};
  int cs[H]   = '{32'h7FFF, 32'h7FFF, 32'h7FFF, 32'h7FFF};
  int ti1[8]  = '{32'h1000, 32'h2000, 32'h3000, 32'h4000,
                  32'h4000, 32'h3000, 32'h2000, 32'h1000};
  int tq2[8]  = '{32'h0800, 32'h1000, 32'h1800, 32'h2000,
                  32'h2000, 32'h1800, 32'h1000, 32'h0800};
  int z8[8]   = '{0, 0, 0, 0, 0, 0, 0, 0};
  int iv[32];
  int ov[32];
  int cr[H];
  int vcnt, ones;

  initial begin
    reset        = 0;
    reload_coeff = 1;
    coeff_in     = 0;
    out_tready   = 1;
    drive(0, 0, 0, 0);
    for (int k = 0; k < H; k++) hm[k] = 0;
    for (int k = 0; k < N; k++) begin
      xi[k] = 0;
      xq[k] = 0;
    end
    #3;
    chk("rst_tvalid", int'(out_tvalid), 0);
    chk("rst_tlast", int'(out_tlast), 0);
    chk("rst_out_i", int'(out_i), 0);
    chk("rst_out_q", int'(out_q), 0);
    chk("rst_in_tready", int'(in_tready), 1);
    #9;
    reset = 1;
    @(posedge clk);
    #1;

    load(c1);
    impulse("imp", 32'h7FFF, 0, -1, ti1, z8);
    impulse("railq", 0, 32'h4000, -1, z8, tq2);
    impulse("bp", 32'h7FFF, 0, 2, ti1, z8);

    load(cs);
    clear_obs();
    repeat (16) begin
      drive(1, 32'h7FFF, 0, 0);
      cycle();
    end
    drain();
    chk("sat_pos", oi[oi.size()-1], 32767);
    clear_obs();
    repeat (16) begin
      drive(1, -32768, 0, 0);
      cycle();
    end
    drain();
    chk("sat_neg", oi[oi.size()-1], -32768);

    clear_obs();
    vcnt = 0;
    for (int t = 0; t < 32; t++) begin
      if (t < 20 && (t % 2) == 0) begin
        drive(1, int'($urandom_range(0, 65535)),
              int'($urandom_range(0, 65535)), vcnt == 4);
        vcnt++;
        iv[t] = 1;
      end else begin
        drive(0, 0, 0, 0);
        iv[t] = 0;
      end
      cycle();
      ov[t] = int'(out_tvalid);
    end
    for (int t = LAT - 1; t < 32; t++)
      chk("tvalid_pattern", ov[t], iv[t-LAT+1]);
    chk("tlast_count_out", ol.size(), 10);
    ones = 0;
    foreach (ol[k]) ones += int'(ol[k]);
    chk("tlast_ones", ones, 1);
    if (ol.size() > 4) chk("tlast_5th", int'(ol[4]), 1);

    for (int k = 0; k < H; k++) cr[k] = $signed(16'($urandom_range(0, 65535)));
    load(cr);
    for (int t = 0; t < 300; t++) begin
      drive($urandom_range(0, 9) < 7, int'($urandom_range(0, 65535)),
            int'($urandom_range(0, 65535)), $urandom_range(0, 7) == 0);
      out_tready = $urandom_range(0, 3) != 0;
      cycle();
    end
    drain();

    load(c1);
    repeat (10) begin
      drive(1, int'($urandom_range(0, 65535)),
            int'($urandom_range(0, 65535)), 0);
      cycle();
    end
    #2;
    reset = 0;
    #1;
    chk("mid_rst_tvalid", int'(out_tvalid), 0);
    chk("mid_rst_tlast", int'(out_tlast), 0);
    chk("mid_rst_out_i", int'(out_i), 0);
    chk("mid_rst_out_q", int'(out_q), 0);
    for (int k = 0; k < H; k++) hm[k] = 0;
    for (int k = 0; k < N; k++) begin
      xi[k] = 0;
      xq[k] = 0;
    end
    eq_i.delete();
    eq_q.delete();
    eq_l.delete();
    reload_coeff = 1;
    drive(0, 0, 0, 0);
    @(posedge clk);
    #3;
    reset = 1;
    @(posedge clk);
    #1;
    impulse("nocoef", 32'h7FFF, 32'h7FFF, -1, z8, z8);
    load(c1);
    impulse("reimp", 32'h7FFF, 0, -1, ti1, z8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
